reset_seq: RTL and testbench

//  Board reset sequencer that replaces the direct areset_n_i -> sys_rst wiring in the top level.

---
 rtl/mexiko_rst_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/reset_seq.sv | 182 ++++++++++++++++++
 tb/tb_reset_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mexiko_rst_pkg.sv
// Shared types for the board reset sequencer.
// State encoding doubles as the debug LED code.
package mexiko_rst_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    NET_WAIT = 3'd1,
    DDR_WAIT = 3'd2,
    RUN      = 3'd3,
    FAIL     = 3'd4
  } rst_state_t;

  localparam logic [1:0] FAIL_NONE = 2'b00;
  localparam logic [1:0] FAIL_NET  = 2'b01;
  localparam logic [1:0] FAIL_DDR  = 2'b10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single async level.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synced out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Board reset sequencer: releases net GTs, then DDR3 MIG, then orpsoc.
// Ports: sys_clk_i, sys_rst_n_i (sync, active-low), net_done_i,
//   ddr_calib_i (async), net_rst_o, ddr_rst_o, soc_rst_o (active-high),
//   done_o, fail_o, fail_code_o[1:0], state_o[2:0].
// Macro RESET_SEQ_RETRY_EN: retry the whole sequence after a timeout.
module reset_seq
  import mexiko_rst_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int NET_TIMEOUT = 1048576,
  parameter int DDR_TIMEOUT = 4194304,
  parameter int MAX_RETRIES = 3,
  parameter int CNT_W       = 24
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       net_done_i,
  input  logic       ddr_calib_i,
  output logic       net_rst_o,
  output logic       ddr_rst_o,
  output logic       soc_rst_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [1:0] fail_code_o,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] NET_LAST  = CNT_W'(NET_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DDR_LAST  = CNT_W'(DDR_TIMEOUT - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= 2**CNT_W ||
      NET_TIMEOUT < 1 || NET_TIMEOUT >= 2**CNT_W ||
      DDR_TIMEOUT < 1 || DDR_TIMEOUT >= 2**CNT_W ||
      MAX_RETRIES < 0) begin : g_bad_param
    $error("reset_seq: cycle parameter out of range");
  end

  rst_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             net_s;
  logic             ddr_s;
  logic             to_hit;
  logic [1:0]       to_code;

`ifdef RESET_SEQ_RETRY_EN
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  logic [RW-1:0] retry_cnt;
`endif

  sync_2ff #(.RST_VAL(1'b0)) u_sync_net (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_n_i),
    .d     (net_done_i),
    .q     (net_s)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_sync_ddr (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_n_i),
    .d     (ddr_calib_i),
    .q     (ddr_s)
  );

  // A timeout only fires when nothing better happens on the same
  // cycle: a done flag, or a net drop while waiting on DDR.
  always_comb begin
    to_hit  = 1'b0;
    to_code = FAIL_NONE;
    if (state == NET_WAIT && !net_s && cnt == NET_LAST) begin
      to_hit  = 1'b1;
      to_code = FAIL_NET;
    end else if (state == DDR_WAIT && !ddr_s && net_s &&
                 cnt == DDR_LAST) begin
      to_hit  = 1'b1;
      to_code = FAIL_DDR;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state       <= HOLD;
      cnt         <= '0;
      net_rst_o   <= 1'b1;
      ddr_rst_o   <= 1'b1;
      soc_rst_o   <= 1'b1;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_code_o <= FAIL_NONE;
`ifdef RESET_SEQ_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else if (to_hit) begin
      fail_code_o <= to_code;
      cnt         <= '0;
      net_rst_o   <= 1'b1;
      ddr_rst_o   <= 1'b1;
      done_o      <= 1'b0;
`ifdef RESET_SEQ_RETRY_EN
      if (retry_cnt < RETRY_MAX) begin
        retry_cnt <= retry_cnt + 1'b1;
        state     <= HOLD;
        soc_rst_o <= 1'b1;
      end else begin
        state     <= FAIL;
        soc_rst_o <= 1'b0;
        fail_o    <= 1'b1;
      end
`else
      state       <= FAIL;
      soc_rst_o   <= 1'b0;
      fail_o      <= 1'b1;
`endif
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            state     <= NET_WAIT;
            net_rst_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        NET_WAIT: begin
          if (net_s) begin
            cnt       <= '0;
            state     <= DDR_WAIT;
            ddr_rst_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DDR_WAIT: begin
          if (ddr_s) begin
            cnt       <= '0;
            state     <= RUN;
            soc_rst_o <= 1'b0;
            done_o    <= 1'b1;
          end else if (!net_s) begin
            // link lost before calib: restart, keep retry budget
            cnt       <= '0;
            state     <= HOLD;
            net_rst_o <= 1'b1;
            ddr_rst_o <= 1'b1;
            soc_rst_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          cnt <= '0;
          if (!net_s || !ddr_s) begin
            state     <= HOLD;
            net_rst_o <= 1'b1;
            ddr_rst_o <= 1'b1;
            soc_rst_o <= 1'b1;
            done_o    <= 1'b0;
`ifdef RESET_SEQ_RETRY_EN
            retry_cnt <= '0;
`endif
          end
        end
        FAIL: begin
          cnt <= '0;
        end
        default: begin
          cnt       <= '0;
          state     <= HOLD;
          net_rst_o <= 1'b1;
          ddr_rst_o <= 1'b1;
          soc_rst_o <= 1'b1;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq.
// Expected output vectors are queued per cycle and compared on negedge.
module tb_reset_seq;

  logic       sys_clk_i = 1'b0;
  logic       sys_rst_n_i;
  logic       net_done_i;
  logic       ddr_calib_i;
  logic       net_rst_o;
  logic       ddr_rst_o;
  logic       soc_rst_o;
  logic       done_o;
  logic       fail_o;
  logic [1:0] fail_code_o;
  logic [2:0] state_o;

  reset_seq #(
    .HOLD_CYCLES (8),
    .NET_TIMEOUT (32),
    .DDR_TIMEOUT (64),
    .MAX_RETRIES (2),
    .CNT_W       (24)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_n_i (sys_rst_n_i),
    .net_done_i  (net_done_i),
    .ddr_calib_i (ddr_calib_i),
    .net_rst_o   (net_rst_o),
    .ddr_rst_o   (ddr_rst_o),
    .soc_rst_o   (soc_rst_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_code_o (fail_code_o),
    .state_o     (state_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int cyc = 0;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int         at;
    string      tag;
    logic [9:0] v;
  } sb_t;

  sb_t sb[$];
  sb_t e;

  logic [9:0] obs;
  assign obs = {net_rst_o, ddr_rst_o, soc_rst_o, done_o, fail_o,
                fail_code_o, state_o};

  // {net_rst, ddr_rst, soc_rst, done, fail, code, state}
  function automatic logic [9:0] pv(input logic n, input logic d,
                                    input logic s, input logic dn,
                                    input logic f, input logic [1:0] c,
                                    input logic [2:0] st);
    return {n, d, s, dn, f, c, st};
  endfunction

  task automatic chk(input string tag, input logic [9:0] got,
                     input logic [9:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  task automatic sb_push(input int at, input string tag,
                         input logic [9:0] v);
    sb_t x;
    x.at  = at;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge sys_clk_i);
  endtask

  always @(negedge sys_clk_i) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, obs, e.v);
    end
  end

  logic [9:0] v_hold, v_net, v_ddr, v_run;

  initial begin
    int b;
    int d;
    v_hold = pv(1, 1, 1, 0, 0, 2'b00, 3'd0);
    v_net  = pv(0, 1, 1, 0, 0, 2'b00, 3'd1);
    v_ddr  = pv(0, 0, 1, 0, 0, 2'b00, 3'd2);
    v_run  = pv(0, 0, 0, 1, 0, 2'b00, 3'd3);
    sys_rst_n_i = 1'b0;
    net_done_i  = 1'b0;
    ddr_calib_i = 1'b0;
    @(negedge sys_clk_i);

    // reset state
    b = cyc;
    sb_push(b + 1, "rst_a", v_hold);
    sb_push(b + 2, "rst_b", v_hold);
    wait_to(b + 2);

    // normal bring-up
    b = cyc;
    sys_rst_n_i = 1'b1;
    sb_push(b + 7,  "t1_hold",    v_hold);
    sb_push(b + 8,  "t1_net",     v_net);
    sb_push(b + 22, "t1_net_end", v_net);
    sb_push(b + 23, "t1_ddr",     v_ddr);
    sb_push(b + 42, "t1_ddr_end", v_ddr);
    sb_push(b + 43, "t1_run",     v_run);
    wait_to(b + 20);
    net_done_i = 1'b1;
    wait_to(b + 40);
    ddr_calib_i = 1'b1;
    wait_to(b + 50);

    // one-cycle calib glitch in RUN
    ddr_calib_i = 1'b0;
    sb_push(b + 52, "t4_run",   v_run);
    sb_push(b + 53, "t4_hold",  v_hold);
    sb_push(b + 60, "t4_hold2", v_hold);
    sb_push(b + 61, "t4_net",   v_net);
    sb_push(b + 62, "t4_ddr",   v_ddr);
    sb_push(b + 63, "t4_run2",  v_run);
    wait_to(b + 51);
    ddr_calib_i = 1'b1;
    wait_to(b + 70);

    // reset pulse mid DDR_WAIT
    b = cyc;
    sys_rst_n_i = 1'b0;
    ddr_calib_i = 1'b0;
    sb_push(b + 1, "t5_rst", v_hold);
    wait_to(b + 1);
    b = cyc;
    sys_rst_n_i = 1'b1;
    sb_push(b + 8, "t5_net", v_net);
    sb_push(b + 9, "t5_ddr", v_ddr);
    wait_to(b + 15);
    sys_rst_n_i = 1'b0;
    sb_push(b + 16, "t5_mid_rst", v_hold);
    wait_to(b + 16);
    sys_rst_n_i = 1'b1;
    b = cyc;
    sb_push(b + 7, "t5_cnt0", v_hold);
    sb_push(b + 8, "t5_net2", v_net);
    sb_push(b + 9, "t5_ddr2", v_ddr);

    // DDR timeout
    d = b + 9;
    sb_push(d + 63, "t6_pre_to", v_ddr);
`ifdef RESET_SEQ_RETRY_EN
    sb_push(d + 64, "t6_retry", pv(1, 1, 1, 0, 0, 2'b10, 3'd0));
    sb_push(d + 72, "t6_net",   pv(0, 1, 1, 0, 0, 2'b10, 3'd1));
    sb_push(d + 73, "t6_ddr",   pv(0, 0, 1, 0, 0, 2'b10, 3'd2));
    sb_push(d + 78, "t6_run",   pv(0, 0, 0, 1, 0, 2'b10, 3'd3));
    wait_to(d + 75);
    ddr_calib_i = 1'b1;
    wait_to(d + 80);
`else
    sb_push(d + 64, "t6_fail",  pv(1, 1, 0, 0, 1, 2'b10, 3'd4));
    sb_push(d + 70, "t6_stay",  pv(1, 1, 0, 0, 1, 2'b10, 3'd4));
    wait_to(d + 71);
`endif

    // network never comes up
    b = cyc;
    sys_rst_n_i = 1'b0;
    net_done_i  = 1'b0;
    ddr_calib_i = 1'b0;
    sb_push(b + 1, "t2_rst", v_hold);
    wait_to(b + 2);
    b = cyc;
    sys_rst_n_i = 1'b1;
    sb_push(b + 39, "t2_pre_to", v_net);
`ifdef RESET_SEQ_RETRY_EN
    sb_push(b + 40,  "t2_hold1", pv(1, 1, 1, 0, 0, 2'b01, 3'd0));
    sb_push(b + 48,  "t2_net2",  pv(0, 1, 1, 0, 0, 2'b01, 3'd1));
    sb_push(b + 80,  "t2_hold2", pv(1, 1, 1, 0, 0, 2'b01, 3'd0));
    sb_push(b + 88,  "t2_net3",  pv(0, 1, 1, 0, 0, 2'b01, 3'd1));
    sb_push(b + 119, "t2_net3e", pv(0, 1, 1, 0, 0, 2'b01, 3'd1));
    sb_push(b + 120, "t2_fail",  pv(1, 1, 0, 0, 1, 2'b01, 3'd4));
    sb_push(b + 130, "t2_stay",  pv(1, 1, 0, 0, 1, 2'b01, 3'd4));
    wait_to(b + 131);
`else
    sb_push(b + 40, "t2_fail", pv(1, 1, 0, 0, 1, 2'b01, 3'd4));
    sb_push(b + 50, "t2_stay", pv(1, 1, 0, 0, 1, 2'b01, 3'd4));
    wait_to(b + 51);
`endif

    // net_done arrives exactly on the timeout cycle
    b = cyc;
    sys_rst_n_i = 1'b0;
    sb_push(b + 1, "t3_rst", v_hold);
    wait_to(b + 2);
    b = cyc;
    sys_rst_n_i = 1'b1;
    sb_push(b + 39, "t3_pre",  v_net);
    sb_push(b + 40, "t3_wins", v_ddr);
    sb_push(b + 41, "t3_keep", v_ddr);
    wait_to(b + 37);
    net_done_i = 1'b1;
    wait_to(b + 45);

    chk("sb_left", 10'(sb.size()), 10'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
